// File: rtl/minesweeper_ctrl.sv
// Minesweeper game controller: accepts player actions, reads the board RAM,
// tracks revealed/flagged cells and counters, and writes display updates.
module minesweeper_ctrl #(
  parameter  int ROWS      = 8,
  parameter  int COLS      = 8,
  parameter  int NUM_MINES = 10,
  localparam int XW        = $clog2(COLS),
  localparam int YW        = $clog2(ROWS),
  localparam int CW        = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_btn,
  input  logic          act_valid,
  output logic          act_ready,
  input  logic          act_flag,
  input  logic [XW-1:0] act_x,
  input  logic [YW-1:0] act_y,
  output logic [YW+XW-1:0] rd_addr,
  input  logic [3:0]    rd_data,
  output logic          wr_en,
  output logic [YW+XW-1:0] wr_addr,
  output logic [3:0]    wr_data,
  output logic [1:0]    status,
  output logic [CW-1:0] flags_left,
  output logic [CW-1:0] revealed_cnt
);

  localparam int AW = YW + XW;
  localparam logic [CW-1:0] SAFE_CNT  = CW'(ROWS*COLS - NUM_MINES);
  localparam logic [CW-1:0] MINES_CNT = CW'(NUM_MINES);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_RD, S_EV, S_WON, S_LOST} state_t;

  state_t state, state_nx;

  logic              init_q;
  logic              init_edge;
  logic              in_range;
  logic              accept;
  logic              lat_flag;
  logic [2**AW-1:0]  revealed;
  logic [2**AW-1:0]  flagged;
  logic              cell_rev, cell_flag;
  logic              ev_write;
  logic [3:0]        ev_data;
  logic              ev_set_rev, ev_set_flag, ev_clr_flag;

  assign init_edge = init_btn & ~init_q;
  assign in_range  = ({1'b0, act_x} < (XW+1)'(COLS)) && ({1'b0, act_y} < (YW+1)'(ROWS));
  assign act_ready = (state == S_PLAY);
  assign accept    = act_ready && act_valid && in_range;
  // rd_addr doubles as the latched cell index for the action in flight
  assign cell_rev  = revealed[rd_addr];
  assign cell_flag = flagged[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ev_write    = 1'b0;
    ev_data     = 4'hF;
    ev_set_rev  = 1'b0;
    ev_set_flag = 1'b0;
    ev_clr_flag = 1'b0;
    status      = 2'b01;
    unique case (state)
      S_IDLE: begin
        status = 2'b00;
        if (init_edge) state_nx = S_PLAY;
      end
      S_PLAY: if (accept) state_nx = S_RD;
      S_RD:   state_nx = S_EV;
      S_EV: begin
        state_nx = S_PLAY;
        if (!lat_flag) begin
          if (!(cell_flag || cell_rev)) begin
            ev_write = 1'b1;
            if (rd_data == 4'd11) begin
              ev_data  = 4'd11;
              state_nx = S_LOST;
            end else begin
              ev_data    = rd_data;
              ev_set_rev = 1'b1;
              if ((revealed_cnt + CW'(1)) == SAFE_CNT) state_nx = S_WON;
            end
          end
        end else if (!cell_rev) begin
          if (cell_flag) begin
            ev_write    = 1'b1;
            ev_data     = 4'hF;
            ev_clr_flag = 1'b1;
          end else if (flags_left != '0) begin
            ev_write    = 1'b1;
            ev_data     = 4'd10;
            ev_set_flag = 1'b1;
          end
        end
      end
      S_WON: begin
        status = 2'b10;
        if (init_edge) state_nx = S_IDLE;
      end
      S_LOST: begin
        status = 2'b11;
        if (init_edge) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q       <= 1'b0;
      lat_flag     <= 1'b0;
      rd_addr      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 4'hF;
      revealed     <= '0;
      flagged      <= '0;
      flags_left   <= MINES_CNT;
      revealed_cnt <= '0;
    end else begin
      init_q <= init_btn;
      wr_en  <= ev_write;
      if (ev_write) begin
        wr_addr <= rd_addr;
        wr_data <= ev_data;
      end
      if (state == S_IDLE) begin
        revealed     <= '0;
        flagged      <= '0;
        flags_left   <= MINES_CNT;
        revealed_cnt <= '0;
      end
      if (accept) begin
        lat_flag <= act_flag;
        rd_addr  <= {act_y, act_x};
      end
      if (ev_set_rev) begin
        revealed[rd_addr] <= 1'b1;
        revealed_cnt      <= revealed_cnt + CW'(1);
      end
      if (ev_set_flag) begin
        flagged[rd_addr] <= 1'b1;
        flags_left       <= flags_left - CW'(1);
      end
      if (ev_clr_flag) begin
        flagged[rd_addr] <= 1'b0;
        flags_left       <= flags_left + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// Directed bench for minesweeper_ctrl: an 8x8/10-mine board and a 3x3/1-mine board.
module tb_minesweeper_ctrl;

  logic       clk = 1'b0;
  logic       rst, init_btn, act_valid, act_flag, sel;
  logic [2:0] act_x, act_y;

  logic       a_ready, a_wr_en, b_ready, b_wr_en;
  logic [5:0] a_rd_addr, a_wr_addr;
  logic [3:0] b_rd_addr, b_wr_addr;
  logic [3:0] a_rd_data, a_wr_data, b_rd_data, b_wr_data;
  logic [1:0] a_status, b_status;
  logic [6:0] a_flags, a_cnt;
  logic [3:0] b_flags, b_cnt;

  logic [3:0] board_a [64];
  logic [3:0] board_b [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  minesweeper_ctrl #(.ROWS(8), .COLS(8), .NUM_MINES(10)) dut_a (
    .clk(clk), .rst(rst), .init_btn(init_btn & ~sel), .act_valid(act_valid & ~sel),
    .act_ready(a_ready), .act_flag(act_flag), .act_x(act_x), .act_y(act_y),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .status(a_status), .flags_left(a_flags), .revealed_cnt(a_cnt));

  minesweeper_ctrl #(.ROWS(3), .COLS(3), .NUM_MINES(1)) dut_b (
    .clk(clk), .rst(rst), .init_btn(init_btn & sel), .act_valid(act_valid & sel),
    .act_ready(b_ready), .act_flag(act_flag), .act_x(act_x[1:0]), .act_y(act_y[1:0]),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .status(b_status), .flags_left(b_flags), .revealed_cnt(b_cnt));

  always_ff @(posedge clk) begin
    a_rd_data <= board_a[a_rd_addr];
    b_rd_data <= board_b[b_rd_addr];
  end

  // Views of whichever DUT is currently selected
  int ready_s, wr_en_s, wr_addr_s, wr_data_s, status_s, flags_s, cnt_s;
  always_comb begin
    ready_s   = sel ? int'(b_ready)   : int'(a_ready);
    wr_en_s   = sel ? int'(b_wr_en)   : int'(a_wr_en);
    wr_addr_s = sel ? int'(b_wr_addr) : int'(a_wr_addr);
    wr_data_s = sel ? int'(b_wr_data) : int'(a_wr_data);
    status_s  = sel ? int'(b_status)  : int'(a_status);
    flags_s   = sel ? int'(b_flags)   : int'(a_flags);
    cnt_s     = sel ? int'(b_cnt)     : int'(a_cnt);
  end

  typedef struct {
    int f; int x; int y; int code;
    int wr; int data; int status; int flags; int cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_code(input int x, input int y, input int code);
    if (sel) board_b[y*4 + x] = 4'(code);
    else     board_a[y*8 + x] = 4'(code);
  endtask

  task automatic pulse_init();
    @(negedge clk); init_btn = 1'b1;
    @(negedge clk); init_btn = 1'b0;
  endtask

  // Issues one action; reports wr_en pulses seen over the following 3 cycles.
  task automatic do_action(input int f, input int x, input int y,
                           output int wr_cnt, output int wr_cyc, output int wdata,
                           output int waddr, output int rdy1);
    wr_cnt = 0; wr_cyc = 0; wdata = -1; waddr = -1; rdy1 = -1;
    @(negedge clk);
    act_flag = f[0]; act_x = 3'(x); act_y = 3'(y); act_valid = 1'b1;
    @(posedge clk); #1 act_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = ready_s;
      if (wr_en_s != 0) begin
        wr_cnt++; wr_cyc = c; wdata = wr_data_s; waddr = wr_addr_s;
      end
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int wc, cyc, wd, wa, r1;
    set_code(v.x, v.y, v.code);
    do_action(v.f, v.x, v.y, wc, cyc, wd, wa, r1);
    chk({nm, " ready_in_rd"}, r1, 0);
    chk({nm, " wr_pulses"}, wc, v.wr);
    if (v.wr != 0) begin
      chk({nm, " wr_latency"}, cyc, 3);
      chk({nm, " wr_data"}, wd, v.data);
      chk({nm, " wr_addr"}, wa, sel ? v.y*4 + v.x : v.y*8 + v.x);
    end
    chk({nm, " status"}, status_s, v.status);
    chk({nm, " flags_left"}, flags_s, v.flags);
    chk({nm, " revealed_cnt"}, cnt_s, v.cnt);
  endtask

  initial begin
    int wc, cyc, wd, wa, r1;
    vecs[0] = '{f:0, x:2, y:3, code:3,  wr:1, data:3,  status:1, flags:10, cnt:1};
    vecs[1] = '{f:0, x:2, y:3, code:3,  wr:0, data:0,  status:1, flags:10, cnt:1};
    vecs[2] = '{f:1, x:5, y:5, code:11, wr:1, data:10, status:1, flags:9,  cnt:1};
    vecs[3] = '{f:0, x:5, y:5, code:11, wr:0, data:0,  status:1, flags:9,  cnt:1};
    vecs[4] = '{f:1, x:5, y:5, code:11, wr:1, data:15, status:1, flags:10, cnt:1};
    vecs[5] = '{f:1, x:2, y:3, code:3,  wr:0, data:0,  status:1, flags:10, cnt:1};
    vecs[6] = '{f:0, x:0, y:0, code:0,  wr:1, data:0,  status:1, flags:10, cnt:2};
    vecs[7] = '{f:0, x:7, y:7, code:8,  wr:1, data:8,  status:1, flags:10, cnt:3};
    vecs[8] = '{f:0, x:6, y:0, code:1,  wr:1, data:1,  status:1, flags:10, cnt:4};
    vecs[9] = '{f:1, x:6, y:0, code:1,  wr:0, data:0,  status:1, flags:10, cnt:4};

    for (int i = 0; i < 64; i++) board_a[i] = 4'd0;
    for (int i = 0; i < 16; i++) board_b[i] = 4'd1;
    sel = 1'b0; init_btn = 1'b0; act_valid = 1'b0; act_flag = 1'b0;
    act_x = '0; act_y = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst status", status_s, 0);
    chk("rst act_ready", ready_s, 0);
    chk("rst flags_left", flags_s, 10);
    chk("rst revealed_cnt", cnt_s, 0);
    chk("rst wr_en", wr_en_s, 0);
    chk("rst wr_data", wr_data_s, 15);
    rst = 1'b0;

    // Start a game on the 8x8 board
    pulse_init();
    chk("init status", status_s, 1);
    chk("init act_ready", ready_s, 1);
    chk("init flags_left", flags_s, 10);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    pulse_init();
    chk("init_in_play ignored", status_s, 1);

    // Spend the whole flag budget, then try one more
    for (int i = 0; i < 10; i++) begin
      set_code(i % 8, 1 + i / 8, 0);
      do_action(1, i % 8, 1 + i / 8, wc, cyc, wd, wa, r1);
      chk($sformatf("budget%0d wr_data", i), wd, 10);
      chk($sformatf("budget%0d flags_left", i), flags_s, 9 - i);
    end
    do_action(1, 2, 2, wc, cyc, wd, wa, r1);
    chk("flag_at_zero wr_pulses", wc, 0);
    chk("flag_at_zero flags_left", flags_s, 0);
    do_action(1, 0, 1, wc, cyc, wd, wa, r1);
    chk("unflag_at_zero wr_data", wd, 15);
    chk("unflag_at_zero flags_left", flags_s, 1);

    // Step on a mine
    set_code(4, 4, 11);
    do_action(0, 4, 4, wc, cyc, wd, wa, r1);
    chk("mine wr_pulses", wc, 1);
    chk("mine wr_data", wd, 11);
    chk("mine status", status_s, 3);
    chk("mine act_ready", ready_s, 0);
    chk("lost holds cnt", cnt_s, 4);
    pulse_init();
    chk("lost->idle status", status_s, 0);
    repeat (2) @(negedge clk);
    chk("idle holds status", status_s, 0);
    pulse_init();
    chk("restart status", status_s, 1);
    chk("restart flags_left", flags_s, 10);
    chk("restart revealed_cnt", cnt_s, 0);
    do_action(0, 2, 3, wc, cyc, wd, wa, r1);
    chk("restart reveal cleared wr_pulses", wc, 1);
    chk("restart reveal cleared cnt", cnt_s, 1);

    // 3x3 board with a single mine at (2,2)
    sel = 1'b1;
    board_b[2*4 + 2] = 4'd11;
    pulse_init();
    chk("b init status", status_s, 1);
    chk("b init flags_left", flags_s, 1);
    do_action(0, 3, 0, wc, cyc, wd, wa, r1);
    chk("b x_out_of_range wr_pulses", wc, 0);
    chk("b x_out_of_range ready", r1, 1);
    chk("b x_out_of_range cnt", cnt_s, 0);
    do_action(0, 0, 3, wc, cyc, wd, wa, r1);
    chk("b y_out_of_range wr_pulses", wc, 0);
    chk("b y_out_of_range cnt", cnt_s, 0);
    for (int i = 0; i < 8; i++) begin
      set_code(i % 3, i / 3, i);
      do_action(0, i % 3, i / 3, wc, cyc, wd, wa, r1);
      chk($sformatf("b reveal%0d wr_data", i), wd, i);
      chk($sformatf("b reveal%0d cnt", i), cnt_s, i + 1);
      chk($sformatf("b reveal%0d status", i), status_s, (i == 7) ? 2 : 1);
    end
    chk("b won act_ready", ready_s, 0);
    pulse_init();
    pulse_init();
    chk("b replay status", status_s, 1);

    // Reset while the action is being evaluated
    @(negedge clk);
    act_flag = 1'b0; act_x = 3'd0; act_y = 3'd0; act_valid = 1'b1;
    @(posedge clk); #1 act_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    wc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_en_s != 0) wc++;
    end
    chk("b rst_in_ev wr_pulses", wc, 0);
    chk("b rst_in_ev status", status_s, 0);
    chk("b rst_in_ev cnt", cnt_s, 0);
    chk("b rst_in_ev flags_left", flags_s, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
